// File: rtl/ppe_pkg.sv
// Shared types and helpers for the pipelined programmable priority encoder.
package ppe_pkg;

  // Per-chunk search results are held in a fixed-size struct, so CHUNK is capped here.
  localparam int PPE_CHUNK_MAX = 256;
  localparam int PPE_IDX_MAX   = 8;

  function automatic int ppe_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                   hi_hit;
    logic [PPE_IDX_MAX-1:0] hi_idx;
    logic                   any_hit;
    logic [PPE_IDX_MAX-1:0] any_idx;
  } ppe_s1_t;

  function automatic logic [PPE_IDX_MAX-1:0] ppe_lsb(input logic [PPE_CHUNK_MAX-1:0] v);
    logic [PPE_IDX_MAX-1:0] idx;
    idx = '0;
    for (int i = PPE_CHUNK_MAX - 1; i >= 0; i--) begin
      if (v[i]) idx = PPE_IDX_MAX'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ppe_chunk_find.sv
// Combinational lowest-set-bit search over one CHUNK-wide slice of the request,
// both unmasked and masked to bits whose global index is at or above the pointer.
module ppe_chunk_find
  import ppe_pkg::*;
#(
  parameter int CHUNK    = 32,
  parameter int LOGW     = 9,
  parameter int CHUNK_ID = 0
) (
  input  logic [CHUNK-1:0] bits_i,
  input  logic [LOGW-1:0]  p_i,
  output ppe_s1_t          res_o
);

  logic [CHUNK-1:0] hi_mask;
  logic [CHUNK-1:0] hi_bits;

  always_comb begin
    for (int j = 0; j < CHUNK; j++) begin
      hi_mask[j] = (CHUNK_ID * CHUNK + j) >= int'(p_i);
    end
    hi_bits         = bits_i & hi_mask;
    res_o.hi_hit    = |hi_bits;
    res_o.hi_idx    = ppe_lsb(PPE_CHUNK_MAX'(hi_bits));
    res_o.any_hit   = |bits_i;
    res_o.any_idx   = ppe_lsb(PPE_CHUNK_MAX'(bits_i));
  end

endmodule

// File: rtl/ppe_pipe_rr.sv
// Three-stage pipelined programmable priority encoder with valid/ready and an
// optional internal round-robin pointer. Macro PPE_ONEHOT_EN adds o_onehot.
module ppe_pipe_rr
  import ppe_pkg::*;
#(
  parameter int W     = 512,
  parameter int CHUNK = 32,
  parameter int LOGW  = ppe_idx_w(W)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    req,
  input  logic [LOGW-1:0] p_enc,
  input  logic            rr_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LOGW-1:0] o_value,
  output logic            o_found,
`ifdef PPE_ONEHOT_EN
  output logic [W-1:0]    o_onehot,
`endif
  output logic [LOGW-1:0] rr_ptr
);

  localparam int NCH = W / CHUNK;

  logic            stall, accept, rr_busy;
  logic            s0_v_q, s0_rr_q;
  logic [W-1:0]    s0_req_q;
  logic [LOGW-1:0] s0_p_q;
  logic            s1_v_q, s1_rr_q;
  ppe_s1_t         s1_q [NCH];
  ppe_s1_t         s1_d [NCH];
  logic            out_v_q, out_rr_q, out_found_q;
  logic [LOGW-1:0] out_value_q;
  logic [LOGW-1:0] rr_ptr_q, rr_ptr_d;
  logic            hi_any, merge_found;
  logic [LOGW-1:0] hi_val, lo_val, merge_value;
`ifdef PPE_ONEHOT_EN
  logic [W-1:0]    onehot_q;
`endif

  // An rr transaction anywhere in the pipe blocks intake so the pointer it
  // produces is visible to the next rr transaction.
  assign stall    = out_v_q && !out_ready;
  assign rr_busy  = (s0_v_q && s0_rr_q) || (s1_v_q && s1_rr_q) || (out_v_q && out_rr_q);
  assign in_ready = !stall && !rr_busy;
  assign accept   = in_valid && in_ready;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chunk
    ppe_chunk_find #(
      .CHUNK    (CHUNK),
      .LOGW     (LOGW),
      .CHUNK_ID (gi)
    ) u_find (
      .bits_i (s0_req_q[gi*CHUNK +: CHUNK]),
      .p_i    (s0_p_q),
      .res_o  (s1_d[gi])
    );
  end

  // Descending scan so the lowest qualifying chunk wins.
  always_comb begin
    hi_any      = 1'b0;
    merge_found = 1'b0;
    hi_val      = '0;
    lo_val      = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (s1_q[c].hi_hit) begin
        hi_any = 1'b1;
        hi_val = LOGW'(c * CHUNK) + LOGW'(s1_q[c].hi_idx);
      end
      if (s1_q[c].any_hit) begin
        merge_found = 1'b1;
        lo_val      = LOGW'(c * CHUNK) + LOGW'(s1_q[c].any_idx);
      end
    end
    merge_value = hi_any ? hi_val : lo_val;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (out_v_q && out_ready && out_rr_q && out_found_q) begin
      rr_ptr_d = out_value_q + LOGW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_v_q      <= 1'b0;
      s0_rr_q     <= 1'b0;
      s0_req_q    <= '0;
      s0_p_q      <= '0;
      s1_v_q      <= 1'b0;
      s1_rr_q     <= 1'b0;
      for (int c = 0; c < NCH; c++) s1_q[c] <= '0;
      out_v_q     <= 1'b0;
      out_rr_q    <= 1'b0;
      out_found_q <= 1'b0;
      out_value_q <= '0;
      rr_ptr_q    <= '0;
`ifdef PPE_ONEHOT_EN
      onehot_q    <= '0;
`endif
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (!stall) begin
        s0_v_q <= accept;
        if (accept) begin
          s0_req_q <= req;
          s0_p_q   <= rr_mode ? rr_ptr_q : p_enc;
          s0_rr_q  <= rr_mode;
        end
        s1_v_q <= s0_v_q;
        if (s0_v_q) begin
          s1_rr_q <= s0_rr_q;
          for (int c = 0; c < NCH; c++) s1_q[c] <= s1_d[c];
        end
        out_v_q <= s1_v_q;
        if (s1_v_q) begin
          out_rr_q    <= s1_rr_q;
          out_found_q <= merge_found;
          out_value_q <= merge_value;
`ifdef PPE_ONEHOT_EN
          onehot_q    <= merge_found ? (W'(1) << merge_value) : '0;
`endif
        end
      end
    end
  end

  assign out_valid = out_v_q;
  assign o_value   = out_value_q;
  assign o_found   = out_found_q;
  assign rr_ptr    = rr_ptr_q;
`ifdef PPE_ONEHOT_EN
  assign o_onehot  = onehot_q;
`endif

endmodule

// File: tb/tb_ppe_pipe_rr.sv
// Directed self-checking bench for ppe_pipe_rr (W=512, CHUNK=32); define
// PPE_ONEHOT_EN to also exercise o_onehot.
module tb_ppe_pipe_rr;
  localparam int W     = 512;
  localparam int CHUNK = 32;
  localparam int LOGW  = 9;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            rr_mode = 1'b0;
  logic            out_ready = 1'b1;
  logic [W-1:0]    req = '0;
  logic [LOGW-1:0] p_enc = '0;
  logic            in_ready, out_valid, o_found;
  logic [LOGW-1:0] o_value, rr_ptr;
`ifdef PPE_ONEHOT_EN
  logic [W-1:0]    o_onehot;
  logic [W-1:0]    cap_onehot;
`endif

  int              checks = 0;
  int              failures = 0;
  logic [LOGW-1:0] cap_value;
  logic            cap_found;
  int              cap_lat;
  logic            cap_rdy_seen;

  always #5 clk = ~clk;

  ppe_pipe_rr #(.W(W), .CHUNK(CHUNK), .LOGW(LOGW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .req       (req),
    .p_enc     (p_enc),
    .rr_mode   (rr_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o_value   (o_value),
    .o_found   (o_found),
`ifdef PPE_ONEHOT_EN
    .o_onehot  (o_onehot),
`endif
    .rr_ptr    (rr_ptr)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] mk2(input int a, input int b);
    logic [W-1:0] v;
    v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    return v;
  endfunction

  // Sends one transaction, waits for its result and consumes it.
  task automatic run_one(input logic [W-1:0] r, input logic [LOGW-1:0] p, input logic rr);
    int guard;
    @(negedge clk);
    req = r; p_enc = p; rr_mode = rr; in_valid = 1'b1; out_ready = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
      failures++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    cap_lat = 1;
    cap_rdy_seen = in_ready;
    while (!out_valid && cap_lat < 20) begin
      @(posedge clk); #1;
      cap_lat++;
      cap_rdy_seen = cap_rdy_seen | in_ready;
    end
    cap_value = o_value;
    cap_found = o_found;
`ifdef PPE_ONEHOT_EN
    cap_onehot = o_onehot;
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || o_value !== '0 || o_found !== 1'b0 || rr_ptr !== '0) begin
      $display("FAIL reset_state: out_valid=%0b o_value=%0d o_found=%0b rr_ptr=%0d required 0 0 0 0",
               out_valid, o_value, o_found, rr_ptr);
      failures++;
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready: in_ready=%0b required 1", in_ready);
      failures++;
    end
  endtask

  task automatic test_external;
    // a/b: request bit positions (-1 none, -2 all ones); p: pointer; v/f: expected result
    int ta [10] = '{5,   5,   5,   -1,  5,   200, 290, 511, 10,  -2};
    int tb [10] = '{300, 300, 300, -1,  300, -1,  300, -1,  20,  -1};
    int tp [10] = '{100, 301, 300, 100, 0,   200, 295, 511, 480, 77};
    int tv [10] = '{300, 5,   300, 0,   5,   200, 300, 511, 10,  77};
    int tf [10] = '{1,   1,   1,   0,   1,   1,   1,   1,   1,   1};
    logic [W-1:0] r;
    for (int i = 0; i < 10; i++) begin
      r = (ta[i] == -2) ? '1 : mk2(ta[i], tb[i]);
      run_one(r, LOGW'(tp[i]), 1'b0);
      checks++;
      if (cap_value !== LOGW'(tv[i])) begin
        $display("FAIL ext_value[%0d]: o_value=%0d required %0d", i, cap_value, tv[i]);
        failures++;
      end
      checks++;
      if (cap_found !== tf[i][0]) begin
        $display("FAIL ext_found[%0d]: o_found=%0b required %0b", i, cap_found, tf[i][0]);
        failures++;
      end
      checks++;
      if (cap_lat != 3) begin
        $display("FAIL ext_latency[%0d]: latency=%0d required 3", i, cap_lat);
        failures++;
      end
    end
    checks++;
    if (rr_ptr !== '0) begin
      $display("FAIL ext_rr_ptr: rr_ptr=%0d required 0", rr_ptr);
      failures++;
    end
  endtask

  task automatic test_back_to_back;
    int sent, got, stall_cycles, idle_valid;
    logic [LOGW-1:0] held;
    sent = 0; got = 0; stall_cycles = 0; idle_valid = 0; held = '0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 6 && cyc < 10);
      rr_mode = 1'b0;
      p_enc = '0;
      in_valid = (sent < 8);
      req = mk2(sent * 61 + 2, -1);
      #1;
      if (out_valid && !out_ready) begin
        if (stall_cycles == 0) begin
          held = o_value;
        end else begin
          checks++;
          if (o_value !== held) begin
            $display("FAIL stall_hold: o_value=%0d required %0d", o_value, held);
            failures++;
          end
        end
        checks++;
        if (in_ready !== 1'b0) begin
          $display("FAIL stall_in_ready: in_ready=%0b required 0", in_ready);
          failures++;
        end
        stall_cycles++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (o_value !== LOGW'(got * 61 + 2)) begin
          $display("FAIL stream_value[%0d]: o_value=%0d required %0d", got, o_value, got * 61 + 2);
          failures++;
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got != 8 || stall_cycles != 4) begin
      $display("FAIL stream_count: results=%0d stall_cycles=%0d required 8 4", got, stall_cycles);
      failures++;
    end
    repeat (5) begin
      @(negedge clk);
      if (out_valid) idle_valid++;
    end
    checks++;
    if (idle_valid != 0) begin
      $display("FAIL stream_dup: extra valid cycles=%0d required 0", idle_valid);
      failures++;
    end
  endtask

  task automatic test_round_robin;
    int ev [5] = '{3, 7, 511, 3, 0};
    int ep [5] = '{4, 8, 0,   4, 4};
    logic [W-1:0] r;
    checks++;
    if (rr_ptr !== '0) begin
      $display("FAIL rr_start: rr_ptr=%0d required 0", rr_ptr);
      failures++;
    end
    for (int i = 0; i < 5; i++) begin
      r = (i == 4) ? '0 : (mk2(3, 7) | mk2(511, -1));
      run_one(r, LOGW'(100), 1'b1);
      checks++;
      if (cap_value !== LOGW'(ev[i]) || cap_found !== (i != 4)) begin
        $display("FAIL rr_value[%0d]: o_value=%0d o_found=%0b required %0d %0b",
                 i, cap_value, cap_found, ev[i], (i != 4));
        failures++;
      end
      checks++;
      if (rr_ptr !== LOGW'(ep[i])) begin
        $display("FAIL rr_ptr[%0d]: rr_ptr=%0d required %0d", i, rr_ptr, ep[i]);
        failures++;
      end
      checks++;
      if (cap_rdy_seen !== 1'b0) begin
        $display("FAIL rr_in_ready[%0d]: in_ready seen=%0b required 0", i, cap_rdy_seen);
        failures++;
      end
    end
  endtask

  task automatic test_reset_midflight;
    int stale;
    stale = 0;
    @(negedge clk);
    rr_mode = 1'b0; p_enc = '0; out_ready = 1'b0;
    in_valid = 1'b1; req = mk2(9, -1);
    @(negedge clk);
    req = mk2(19, -1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      $display("FAIL midflight_pre: out_valid=%0b required 1", out_valid);
      failures++;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || rr_ptr !== '0) begin
      $display("FAIL midflight_reset: out_valid=%0b rr_ptr=%0d required 0 0", out_valid, rr_ptr);
      failures++;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checks++;
    if (stale != 0 || in_ready !== 1'b1) begin
      $display("FAIL midflight_stale: stale results=%0d in_ready=%0b required 0 1", stale, in_ready);
      failures++;
    end
  endtask

`ifdef PPE_ONEHOT_EN
  task automatic test_onehot;
    run_one(mk2(37, -1), '0, 1'b0);
    checks++;
    if (cap_onehot !== mk2(37, -1)) begin
      $display("FAIL onehot_bit37: o_onehot=%0h required %0h", cap_onehot, mk2(37, -1));
      failures++;
    end
    run_one('0, '0, 1'b0);
    checks++;
    if (cap_onehot !== '0) begin
      $display("FAIL onehot_zero: o_onehot=%0h required 0", cap_onehot);
      failures++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_external();
    test_back_to_back();
    test_round_robin();
    test_reset_midflight();
`ifdef PPE_ONEHOT_EN
    test_onehot();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
